// File: rtl/keypad_scan_display.sv
// rtl/keypad_scan_display.sv - front-panel divider, debounced 3x3 keypad scanner and seven-segment decoder
//
// Ports:
//   CLOCK_50     system clock
//   reset        asynchronous, active-low reset
//   counter_max  divider reload value
//   div_enable   divider count enable
//   counter      divider value, zero marks the tick
//   row          keypad rows, active-low
//   column       keypad column drive, active-low one-hot
//   key          last accepted key index row*3+col, 15 when none
//   valid_key    high while a debounced key is held
//   key_down     one-cycle pulse on press acceptance
//   binary       value to display
//   bdd_enable   decoder load enable
//   hex          segments {g,f,e,d,c,b,a}, active-low
module keypad_scan_display #(
    parameter int SCAN_DIV = 50_000,
    parameter int DEBOUNCE = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [27:0] counter_max,
    input  logic        div_enable,
    output logic [27:0] counter,
    input  logic [2:0]  row,
    output logic [2:0]  column,
    output logic [3:0]  key,
    output logic        valid_key,
    output logic        key_down,
    input  logic [3:0]  binary,
    input  logic        bdd_enable,
    output logic [6:0]  hex
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_CONFIRM,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [27:0] counter_q, counter_d;

    always_comb begin
        counter_d = counter_q;
        if (div_enable) begin
            // counter_max is only sampled here, so a new value waits for the reload
            counter_d = (counter_q == 28'd0) ? counter_max : counter_q - 28'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            counter_q <= counter_max;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign counter = counter_q;

    // ------------------------------------------------------------------
    // Row synchronizer and column dwell timer
    // ------------------------------------------------------------------
    logic [2:0]         row_meta_q, row_sync_q;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dwell_end;

    assign dwell_end = (dwell_q == DWELL_LAST);
    assign dwell_d   = dwell_end ? '0 : dwell_q + DWELL_W'(1);

    // Synchronizer clears to all-low; it refills with live rows long before
    // the first dwell-end sample, so no false press is seen out of reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 3'b000;
            row_sync_q <= 3'b000;
            dwell_q    <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            dwell_q    <= dwell_d;
        end
    end

    // ------------------------------------------------------------------
    // Scanner FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [1:0]      col_q, col_d, col_next;
    logic [1:0]      cand_q, cand_d;
    logic [DB_W-1:0] db_q, db_d, db_inc;
    logic [3:0]      key_q, key_d;
    logic            valid_q, valid_d;
    logic            key_down_q, key_down_d;
    logic            any_low;
    logic [1:0]      low_idx;
    logic            cand_low;

    function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
        key_index = {1'b0, r, 1'b0} + {2'b00, r} + {2'b00, c};
    endfunction

    assign col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign any_low  = ~&row_sync_q;
    assign db_inc   = db_q + DB_ONE;

    // Lowest-indexed low row wins when several rows in a column are pressed
    always_comb begin
        low_idx = 2'd2;
        if (!row_sync_q[0]) begin
            low_idx = 2'd0;
        end else if (!row_sync_q[1]) begin
            low_idx = 2'd1;
        end
    end

    always_comb begin
        case (cand_q)
            2'd0:    cand_low = ~row_sync_q[0];
            2'd1:    cand_low = ~row_sync_q[1];
            2'd2:    cand_low = ~row_sync_q[2];
            default: cand_low = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cand_d     = cand_q;
        db_d       = db_q;
        key_d      = key_q;
        valid_d    = valid_q;
        key_down_d = 1'b0;
        if (dwell_end) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        cand_d = low_idx;
                        if (DB_TARGET == DB_ONE) begin
                            key_d      = key_index(low_idx, col_q);
                            valid_d    = 1'b1;
                            key_down_d = 1'b1;
                            db_d       = '0;
                            state_d    = ST_HELD;
                        end else begin
                            db_d    = DB_ONE;
                            state_d = ST_CONFIRM;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                ST_CONFIRM: begin
                    if (cand_low) begin
                        if (db_inc == DB_TARGET) begin
                            key_d      = key_index(cand_q, col_q);
                            valid_d    = 1'b1;
                            key_down_d = 1'b1;
                            db_d       = '0;
                            state_d    = ST_HELD;
                        end else begin
                            db_d = db_inc;
                        end
                    end else begin
                        // Bounce: drop the candidate and keep scanning
                        db_d    = '0;
                        state_d = ST_SCAN;
                        col_d   = col_next;
                    end
                end
                ST_HELD: begin
                    if (!cand_low) begin
                        if (DB_TARGET == DB_ONE) begin
                            valid_d = 1'b0;
                            db_d    = '0;
                            state_d = ST_SCAN;
                            col_d   = col_next;
                        end else begin
                            db_d    = DB_ONE;
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cand_low) begin
                        if (db_inc == DB_TARGET) begin
                            valid_d = 1'b0;
                            db_d    = '0;
                            state_d = ST_SCAN;
                            col_d   = col_next;
                        end else begin
                            db_d = db_inc;
                        end
                    end else begin
                        db_d    = '0;
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    db_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SCAN;
            col_q      <= 2'd0;
            cand_q     <= 2'd0;
            db_q       <= '0;
            key_q      <= 4'd15;
            valid_q    <= 1'b0;
            key_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cand_q     <= cand_d;
            db_q       <= db_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            key_down_q <= key_down_d;
        end
    end

    always_comb begin
        case (col_q)
            2'd0:    column = 3'b110;
            2'd1:    column = 3'b101;
            2'd2:    column = 3'b011;
            default: column = 3'b111;
        endcase
    end

    assign key       = key_q;
    assign valid_key = valid_q;
    assign key_down  = key_down_q;

    // ------------------------------------------------------------------
    // Seven-segment decoder
    // ------------------------------------------------------------------
    logic [6:0] hex_q, hex_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign hex_d = bdd_enable ? seg_decode(binary) : hex_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            hex_q <= 7'b1111111;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex = hex_q;

endmodule

// File: tb/tb_keypad_scan_display.sv
// tb/tb_keypad_scan_display.sv - directed self-checking bench for keypad_scan_display
module tb_keypad_scan_display;

    logic        CLOCK_50;
    logic        reset;
    logic [27:0] counter_max;
    logic        div_enable;
    logic [27:0] counter;
    logic [2:0]  row;
    logic [2:0]  column;
    logic [3:0]  key;
    logic        valid_key;
    logic        key_down;
    logic [3:0]  binary;
    logic        bdd_enable;
    logic [6:0]  hex;

    int checks = 0;
    int errors = 0;
    int kd_count = 0;

    keypad_scan_display #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .counter_max(counter_max),
        .div_enable (div_enable),
        .counter    (counter),
        .row        (row),
        .column     (column),
        .key        (key),
        .valid_key  (valid_key),
        .key_down   (key_down),
        .binary     (binary),
        .bdd_enable (bdd_enable),
        .hex        (hex)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (key_down === 1'b1) kd_count <= kd_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge right after the column switches to target
    task automatic wait_col(input logic [2:0] target);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (column == target && n < 64) begin
            @(negedge CLOCK_50);
            n++;
        end
        while (!found && n < 64) begin
            @(negedge CLOCK_50);
            n++;
            if (column == target) found = 1'b1;
        end
        check("wait_col", 32'(found), 32'd1);
    endtask

    // Press accepted after 2 sync + 2 remaining dwell + 4 confirm cycles = 8
    task automatic do_press(input logic [2:0] col_pat, input logic [2:0] row_val, input logic [3:0] exp_key);
        int kd0;
        wait_col(col_pat);
        row = row_val;
        kd0 = kd_count;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLOCK_50);
            check("press_pre_valid", 32'(valid_key), 32'd0);
        end
        @(negedge CLOCK_50);
        check("press_key_down", 32'(key_down), 32'd1);
        check("press_valid", 32'(valid_key), 32'd1);
        check("press_key", 32'(key), 32'(exp_key));
        repeat (12) @(negedge CLOCK_50);
        check("press_one_pulse", 32'(kd_count - kd0), 32'd1);
        check("press_col_frozen", 32'(column), 32'(col_pat));
        check("press_still_valid", 32'(valid_key), 32'd1);
    endtask

    // Entered on a dwell boundary; valid drops 8 cycles after rows go high
    task automatic do_release(input logic [3:0] exp_key, input logic [2:0] next_col);
        int kd0;
        row = 3'b111;
        kd0 = kd_count;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLOCK_50);
            check("release_pre_valid", 32'(valid_key), 32'd1);
        end
        @(negedge CLOCK_50);
        check("release_valid", 32'(valid_key), 32'd0);
        check("release_key_kept", 32'(key), 32'(exp_key));
        check("release_no_kd", 32'(key_down), 32'd0);
        check("release_next_col", 32'(column), 32'(next_col));
        @(negedge CLOCK_50);
        check("release_no_pulse", 32'(kd_count - kd0), 32'd0);
    endtask

    initial begin
        int kd0;
        reset       = 1'b0;
        counter_max = 28'd4;
        div_enable  = 1'b0;
        row         = 3'b111;
        binary      = 4'd0;
        bdd_enable  = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        check("rst_counter", 32'(counter), 32'd4);
        check("rst_column", 32'(column), 32'b110);
        check("rst_key", 32'(key), 32'd15);
        check("rst_valid", 32'(valid_key), 32'd0);
        check("rst_key_down", 32'(key_down), 32'd0);
        check("rst_hex", 32'(hex), 32'b1111111);

        // Divider: 4,3,2,1,0,4,...
        reset      = 1'b1;
        div_enable = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLOCK_50);
            check("div_seq", 32'(counter), 32'(4 - (i % 5)));
        end
        div_enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLOCK_50);
            check("div_hold", 32'(counter), 32'd2);
        end
        div_enable  = 1'b1;
        counter_max = 28'd2;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLOCK_50);
            check("div_newmax", 32'(counter), 32'(2 - (i % 3)));
        end

        // Decoder
        bdd_enable = 1'b1;
        binary     = 4'd3;
        @(negedge CLOCK_50);
        check("hex_3", 32'(hex), 32'b0110000);
        binary = 4'd12;
        @(negedge CLOCK_50);
        check("hex_12", 32'(hex), 32'b1111111);
        binary = 4'd8;
        @(negedge CLOCK_50);
        check("hex_8", 32'(hex), 32'b0000000);
        binary = 4'd0;
        @(negedge CLOCK_50);
        check("hex_0", 32'(hex), 32'b1000000);
        bdd_enable = 1'b0;
        binary     = 4'd7;
        repeat (2) begin
            @(negedge CLOCK_50);
            check("hex_hold", 32'(hex), 32'b1000000);
        end

        // Bounce: one low sample on column 0, then high
        wait_col(3'b110);
        kd0 = kd_count;
        row = 3'b110;
        repeat (4) @(negedge CLOCK_50);
        check("bounce_col_frozen", 32'(column), 32'b110);
        row = 3'b111;
        repeat (4) @(negedge CLOCK_50);
        check("bounce_col_resume", 32'(column), 32'b101);
        check("bounce_key", 32'(key), 32'd15);
        check("bounce_valid", 32'(valid_key), 32'd0);
        @(negedge CLOCK_50);
        check("bounce_no_pulse", 32'(kd_count - kd0), 32'd0);

        // Row 1 on column 2 -> 1*3+2
        do_press(3'b011, 3'b101, 4'd5);
        do_release(4'd5, 3'b110);

        // Row 2 on column 1 -> 2*3+1
        do_press(3'b101, 3'b011, 4'd7);
        do_release(4'd7, 3'b011);

        // Rows 0 and 1 together on column 0: row 0 wins
        do_press(3'b110, 3'b100, 4'd0);

        // Asynchronous reset while the key is held
        kd0 = kd_count;
        #3;
        reset = 1'b0;
        #1;
        check("rst_hold_key", 32'(key), 32'd15);
        check("rst_hold_valid", 32'(valid_key), 32'd0);
        check("rst_hold_column", 32'(column), 32'b110);
        check("rst_hold_hex", 32'(hex), 32'b1111111);
        check("rst_hold_counter", 32'(counter), 32'd2);
        @(negedge CLOCK_50);
        reset = 1'b1;
        row   = 3'b111;
        repeat (20) @(negedge CLOCK_50);
        check("rst_hold_no_pulse", 32'(kd_count - kd0), 32'd0);
        check("rst_hold_key_after", 32'(key), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
